// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a shared multi-cycle memory (p0 = fetch, p1 = data).
// Optional macro ARB_RR_EN selects round-robin tie-breaking; default is fixed priority to p1.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_cs,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic [31:0]           p0_dout,
    output logic                  p0_stall,
    input  logic                  p1_cs,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic [31:0]           p1_dout,
    output logic                  p1_stall,
    output logic                  mem_cs,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_din,
    input  logic                  mem_stall,
    output logic [1:0]            owner,
    output logic                  timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    localparam int unsigned WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          gnt0, gnt1, ack0, ack1, own_cs, pick1;

`ifdef ARB_RR_EN
    logic last_q, last_d;
`endif

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);
    // A dropped request aborts the grant; no ack is delivered even if memory answers.
    assign ack0 = gnt0 & p0_cs & ~mem_stall;
    assign ack1 = gnt1 & p1_cs & ~mem_stall;

    assign mem_cs   = gnt0 | gnt1;
    assign mem_addr = gnt0 ? p0_addr : (gnt1 ? p1_addr : '0);

    // Gated by rst so stalls drop the instant reset asserts, even with cs held high.
    assign p0_stall = rst & p0_cs & ~ack0;
    assign p1_stall = rst & p1_cs & ~ack1;
    assign p0_dout  = ack0 ? mem_din : 32'd0;
    assign p1_dout  = ack1 ? mem_din : 32'd0;

    assign owner       = owner_q;
    assign timeout_err = err_q;
    assign own_cs      = gnt0 ? p0_cs : p1_cs;

`ifdef ARB_RR_EN
    assign pick1 = p1_cs & (~p0_cs | ~last_q);
`else
    assign pick1 = p1_cs;
`endif

    always_comb begin
        state_d = state_q;
        wdog_d  = '0;
        err_d   = err_q;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE, ST_REL: begin
                if (p0_cs || p1_cs) begin
                    state_d = pick1 ? ST_GNT1 : ST_GNT0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (!own_cs) begin
                    state_d = ST_REL;
                end else if (ack0 || ack1) begin
                    state_d = ST_REL;
`ifdef ARB_RR_EN
                    last_d  = gnt1;
`endif
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = ST_REL;
                    err_d   = 1'b1;
`ifdef ARB_RR_EN
                    last_d  = gnt1;
`endif
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        owner_d = 2'b00;
        if (state_d == ST_GNT0) begin
            owner_d = 2'b01;
        end else if (state_d == ST_GNT1) begin
            owner_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= 2'b00;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

`ifdef ARB_RR_EN
    // Reset to 1 so p0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table plus multi-cycle sequences
// driven through a behavioural memory that acks on its 7th selected cycle.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        p0_cs, p1_cs, p0_stall, p1_stall, mem_cs, mem_stall, timeout_err;
    logic [31:0] p0_addr, p1_addr, mem_addr, p0_dout, p1_dout, mem_din;
    logic [1:0]  owner;

    logic        use_model, stuck, v_mstall;
    logic [31:0] v_mdin;
    int          mcnt;
    int          tests, fails;

    mem_port_arbiter #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .p0_cs(p0_cs), .p0_addr(p0_addr), .p0_dout(p0_dout), .p0_stall(p0_stall),
        .p1_cs(p1_cs), .p1_addr(p1_addr), .p1_dout(p1_dout), .p1_stall(p1_stall),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_din(mem_din), .mem_stall(mem_stall),
        .owner(owner), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'd4) ? 32'hDEADBEEF : (a * 32'h01010101) ^ 32'h13579BDF;
    endfunction

    // Memory samples on negedge; counter restarts whenever cs is low.
    always @(negedge clk or negedge rst) begin
        if (!rst) mcnt <= 0;
        else      mcnt <= mem_cs ? mcnt + 1 : 0;
    end

    assign mem_stall = use_model ? (stuck | ~(mem_cs & (mcnt >= 7))) : v_mstall;
    assign mem_din   = use_model ? word(mem_addr) : v_mdin;

    typedef struct {
        logic        p0c;
        logic [31:0] p0a;
        logic        p1c;
        logic [31:0] p1a;
        logic        ms;
        logic [31:0] md;
        logic        e_cs;
        logic [31:0] e_addr;
        logic [1:0]  e_own;
        logic        e_s0, e_s1;
        logic [31:0] e_d0, e_d1;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        p0_cs = 1'b0; p1_cs = 1'b0; p0_addr = '0; p1_addr = '0;
        stuck = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
    endtask

    task automatic wait_ack(input bit port, output int n);
        n = 0;
        while ((port ? p1_stall : p0_stall) && n < 60) begin
            tick();
            #6;
            n++;
        end
        if (n >= 60) check("ack_timeout", 1, 0);
    endtask

    initial begin
        int   n;
        int   acks;
        bit   exp_rel;
        logic [1:0] seq [3];
        logic [1:0] exp_seq [3];
        logic [31:0] addrs [3];

        tests = 0; fails = 0;
        use_model = 1'b0; v_mstall = 1'b1; v_mdin = '0;
        do_reset();
        check("reset_state", {mem_cs, mem_addr, owner, p0_stall, p1_stall, p0_dout, p1_dout,
                              timeout_err}, '0);

        //         p0c p0a    p1c p1a    ms  md            cs  addr   own   s0 s1 d0 d1
        vecs[0]  = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        0, 32'h00, 2'b00, 0, 0, 32'h0, 32'h0};
        vecs[1]  = '{1, 32'h10, 0, 32'h00, 1, 32'h0,        0, 32'h00, 2'b00, 1, 0, 32'h0, 32'h0};
        vecs[2]  = '{1, 32'h10, 1, 32'h20, 1, 32'h0,        1, 32'h10, 2'b01, 1, 1, 32'h0, 32'h0};
        vecs[3]  = '{1, 32'h10, 1, 32'h20, 0, 32'h11111111, 1, 32'h10, 2'b01, 0, 1,
                     32'h11111111, 32'h0};
        vecs[4]  = '{0, 32'h10, 1, 32'h20, 0, 32'h22222222, 0, 32'h00, 2'b00, 0, 1, 32'h0, 32'h0};
        vecs[5]  = '{0, 32'h99, 1, 32'h20, 0, 32'h33333333, 1, 32'h20, 2'b10, 0, 0, 32'h0,
                     32'h33333333};
        vecs[6]  = '{0, 32'h00, 0, 32'h00, 0, 32'h44444444, 0, 32'h00, 2'b00, 0, 0, 32'h0, 32'h0};
        vecs[7]  = '{1, 32'h60, 0, 32'h00, 1, 32'h0,        0, 32'h00, 2'b00, 1, 0, 32'h0, 32'h0};
        vecs[8]  = '{0, 32'h60, 0, 32'h00, 0, 32'h55555555, 1, 32'h60, 2'b01, 0, 0, 32'h0, 32'h0};
        vecs[9]  = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        0, 32'h00, 2'b00, 0, 0, 32'h0, 32'h0};
        vecs[10] = '{0, 32'h00, 1, 32'h70, 0, 32'h66666666, 0, 32'h00, 2'b00, 0, 1, 32'h0, 32'h0};
        vecs[11] = '{1, 32'h80, 1, 32'h70, 0, 32'h77777777, 1, 32'h70, 2'b10, 1, 0, 32'h0,
                     32'h77777777};
        vecs[12] = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        0, 32'h00, 2'b00, 0, 0, 32'h0, 32'h0};

        for (int i = 0; i < 13; i++) begin
            tick();
            p0_cs = vecs[i].p0c; p0_addr = vecs[i].p0a;
            p1_cs = vecs[i].p1c; p1_addr = vecs[i].p1a;
            v_mstall = vecs[i].ms; v_mdin = vecs[i].md;
            #6;
            check($sformatf("vec%0d", i),
                  {mem_cs, mem_addr, owner, p0_stall, p1_stall, p0_dout, p1_dout, timeout_err},
                  {vecs[i].e_cs, vecs[i].e_addr, vecs[i].e_own, vecs[i].e_s0, vecs[i].e_s1,
                   vecs[i].e_d0, vecs[i].e_d1, 1'b0});
        end

        // Single read of 0xDEADBEEF: seven stalled cycles, then ack, then a release cycle.
        use_model = 1'b1;
        tick();
        p0_cs = 1'b1; p0_addr = 32'd4;
        #6;
        n = 0;
        while (p0_stall && n < 60) begin
            n++;
            tick();
            #6;
        end
        check("t1_stall_cycles", n, 7);
        check("t1_dout", {owner, p0_dout}, {2'b01, 32'hDEADBEEF});
        tick();
        p0_cs = 1'b0;
        #6;
        check("t1_release", {mem_cs, owner}, {1'b0, 2'b00});

        // Requester drops cs in its third grant cycle.
        tick();
        p0_cs = 1'b1; p0_addr = 32'd16;
        #6;
        tick(); #6;
        check("t3_granted", {mem_cs, owner}, {1'b1, 2'b01});
        tick(); #6;
        tick();
        p0_cs = 1'b0;
        #6;
        check("t3_drop_cycle", {mem_cs, p0_dout}, {1'b1, 32'h0});
        tick(); #6;
        check("t3_after", {mem_cs, p0_stall, timeout_err, owner}, {1'b0, 1'b0, 1'b0, 2'b00});

        // Memory stuck in stall: abort after 16 grant cycles, error is sticky.
        tick();
        stuck = 1'b1;
        p0_cs = 1'b1; p0_addr = 32'd20;
        #6;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tick(); #6;
            if (!mem_cs) break;
            n++;
        end
        check("t4_gnt_cycles", n, 16);
        check("t4_abort", {timeout_err, p0_stall, owner}, {1'b1, 1'b1, 2'b00});
        tick(); #6;
        check("t4_regrant", {mem_cs, owner}, {1'b1, 2'b01});
        stuck = 1'b0;
        wait_ack(1'b0, n);
        check("t4_data", {p0_dout, timeout_err}, {word(32'd20), 1'b1});
        tick();
        p0_cs = 1'b0;
        #6;

        // Asynchronous reset in the middle of a p1 grant.
        tick();
        p1_cs = 1'b1; p1_addr = 32'd24;
        #6;
        tick(); #6;
        check("t5_granted", {mem_cs, owner}, {1'b1, 2'b10});
        rst = 1'b0;
        #1;
        check("t5_async_reset", {mem_cs, p1_stall, owner, p1_dout, timeout_err}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("t5_idle", {mem_cs, owner, p1_stall}, {1'b0, 2'b00, 1'b1});
        wait_ack(1'b1, n);
        check("t5_regrant", {n, owner, p1_dout}, {32'd7, 2'b10, word(32'd24)});
        tick();
        p1_cs = 1'b0;
        #6;

        // Three back-to-back p1 reads with exactly one idle memory cycle between them.
        addrs[0] = 32'd32; addrs[1] = 32'd36; addrs[2] = 32'd40;
        tick();
        p1_cs = 1'b1; p1_addr = addrs[0];
        #6;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b1, n);
            check($sformatf("t6_read%0d", k), {n, p1_dout}, {32'd7, word(addrs[k])});
            tick();
            if (k < 2) p1_addr = addrs[k+1];
            else       p1_cs = 1'b0;
            #6;
            check($sformatf("t6_rel%0d", k), {mem_cs, mem_addr}, {1'b0, 32'h0});
        end

        // Simultaneous continuous requests from a fresh reset.
        do_reset();
`ifdef ARB_RR_EN
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd0;
`else
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd1; exp_seq[2] = 2'd1;
`endif
        seq[0] = 2'd3; seq[1] = 2'd3; seq[2] = 2'd3;
        tick();
        p0_cs = 1'b1; p0_addr = 32'd8;
        p1_cs = 1'b1; p1_addr = 32'd12;
        #6;
        acks = 0;
        exp_rel = 1'b0;
        for (int c = 0; c < 200 && acks < 3; c++) begin
            tick(); #6;
            if (exp_rel) begin
                check("t2_rel", mem_cs, 1'b0);
                exp_rel = 1'b0;
            end else if (!p0_stall) begin
                check("t2_p0_data", p0_dout, word(32'd8));
                seq[acks] = 2'd0;
                acks++;
                exp_rel = 1'b1;
            end else if (!p1_stall) begin
                check("t2_p1_data", p1_dout, word(32'd12));
                seq[acks] = 2'd1;
                acks++;
                exp_rel = 1'b1;
            end
        end
        check("t2_ack_count", acks, 3);
        check("t2_order", {seq[0], seq[1], seq[2]}, {exp_seq[0], exp_seq[1], exp_seq[2]});
        tick();
        p0_cs = 1'b0; p1_cs = 1'b0;
        #6;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
